// File: rtl/wb_arb2_rr.sv
// Two-master, one-slave Wishbone B3 classic round-robin arbiter with a bus
// watchdog that terminates stalled strobes with ERR.
module wb_arb2_rr #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state_q, state_d, arb;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall, fire;

  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Release reuses the idle arbitration in the same cycle, so a waiting
  // master is handed the bus with no dead cycle.
  always_comb begin
    arb = IDLE;
    if (m0_cyc_i && m1_cyc_i) arb = last_q ? G0 : G1;
    else if (m0_cyc_i)        arb = G0;
    else if (m1_cyc_i)        arb = G1;

    state_d = arb;
    if (state_q == G0 && m0_cyc_i) state_d = G0;
    if (state_q == G1 && m1_cyc_i) state_d = G1;

    last_d = last_q;
    if (state_d == G0) last_d = 1'b0;
    if (state_d == G1) last_d = 1'b1;
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    grant_o = 2'b00;
    case (state_q)
      G0: begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        grant_o = 2'b01;
      end
      G1: begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        grant_o = 2'b10;
      end
      default: ;
    endcase
  end

  // A slave ACK/ERR in the firing cycle removes the stall, so it wins.
  always_comb begin
    stall = s_stb_o && !s_ack_i && !s_err_i;
    fire  = 1'b0;
    if (TIMEOUT > 0) fire = stall && (cnt_q == CW'(TIMEOUT - 1));

    cnt_d = cnt_q;
    if (state_d != state_q || state_d == IDLE || s_ack_i || s_err_i || fire)
      cnt_d = '0;
    else if (stall)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    m0_ack_o  = (state_q == G0) && s_ack_i;
    m0_err_o  = (state_q == G0) && (s_err_i || fire);
    m1_ack_o  = (state_q == G1) && s_ack_i;
    m1_err_o  = (state_q == G1) && (s_err_i || fire);
    timeout_o = fire;
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Directed and randomized bench for wb_arb2_rr against a cycle-level
// ownership model; a TIMEOUT=0 copy shares the inputs.
module tb_wb_arb2_rr;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic wb_clk = 1'b0;
  logic wb_rst_n;
  always #5 wb_clk = ~wb_clk;

  logic          mc [2];
  logic          ms [2];
  logic          mw [2];
  logic [AW-1:0] ma [2];
  logic [DW-1:0] md [2];
  logic [SW-1:0] msl[2];
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i;

  logic [DW-1:0] m0_dat_o, m1_dat_o, nt_m0_dat_o, nt_m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          nt_m0_ack_o, nt_m0_err_o, nt_m1_ack_o, nt_m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, nt_s_cyc_o, nt_s_stb_o, nt_s_we_o;
  logic [AW-1:0] s_adr_o, nt_s_adr_o;
  logic [DW-1:0] s_dat_o, nt_s_dat_o;
  logic [SW-1:0] s_sel_o, nt_s_sel_o;
  logic [1:0]    grant_o, nt_grant_o;
  logic          timeout_o, nt_timeout_o;

  wb_arb2_rr #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_adr_i(ma[0]),
    .m0_dat_i(md[0]), .m0_sel_i(msl[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_adr_i(ma[1]),
    .m1_dat_i(md[1]), .m1_sel_i(msl[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  wb_arb2_rr #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut_nt (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_adr_i(ma[0]),
    .m0_dat_i(md[0]), .m0_sel_i(msl[0]), .m0_dat_o(nt_m0_dat_o),
    .m0_ack_o(nt_m0_ack_o), .m0_err_o(nt_m0_err_o),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_adr_i(ma[1]),
    .m1_dat_i(md[1]), .m1_sel_i(msl[1]), .m1_dat_o(nt_m1_dat_o),
    .m1_ack_o(nt_m1_ack_o), .m1_err_o(nt_m1_err_o),
    .s_cyc_o(nt_s_cyc_o), .s_stb_o(nt_s_stb_o), .s_we_o(nt_s_we_o),
    .s_adr_o(nt_s_adr_o), .s_dat_o(nt_s_dat_o), .s_sel_o(nt_s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(nt_grant_o), .timeout_o(nt_timeout_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int owner = -1;   // -1 none, else index of master holding the bus
  int last = 1;
  int stalls = 0;
  int fires = 0;
  int nt_fires = 0;
  bit fire_e;

  task automatic check_eq(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    bit stall;
    int nxt;
    logic [127:0] sbus;
    logic [1:0] g;
    #1;
    stall  = owner >= 0 && ms[owner] && !s_ack_i && !s_err_i;
    fire_e = stall && stalls == TO - 1;
    sbus   = '0;
    if (owner >= 0) sbus = {mc[owner], ms[owner], mw[owner], ma[owner], md[owner], msl[owner]};
    g = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    check_eq("s_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}, sbus);
    check_eq("grant", grant_o, g);
    check_eq("term", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o},
             {owner == 0 && s_ack_i, owner == 0 && (s_err_i || fire_e),
              owner == 1 && s_ack_i, owner == 1 && (s_err_i || fire_e)});
    check_eq("timeout", timeout_o, fire_e);
    check_eq("rdata", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    check_eq("nt_s_bus", {nt_s_cyc_o, nt_s_stb_o, nt_s_we_o, nt_s_adr_o, nt_s_dat_o, nt_s_sel_o}, sbus);
    check_eq("nt_grant", nt_grant_o, g);
    check_eq("nt_term", {nt_m0_ack_o, nt_m0_err_o, nt_m1_ack_o, nt_m1_err_o},
             {owner == 0 && s_ack_i, owner == 0 && s_err_i,
              owner == 1 && s_ack_i, owner == 1 && s_err_i});
    check_eq("nt_timeout", nt_timeout_o, 1'b0);
    if (timeout_o) fires++;
    if (nt_timeout_o) nt_fires++;
    @(posedge wb_clk);
    if (!wb_rst_n) begin
      owner = -1; last = 1; stalls = 0;
    end else begin
      if (owner >= 0 && mc[owner]) nxt = owner;
      else if (mc[0] && mc[1])     nxt = 1 - last;
      else if (mc[0])              nxt = 0;
      else if (mc[1])              nxt = 1;
      else                         nxt = -1;
      if (s_ack_i || s_err_i || fire_e || nxt != owner) stalls = 0;
      else if (stall) stalls++;
      if (nxt >= 0) last = nxt;
      owner = nxt;
    end
    @(negedge wb_clk);
  endtask

  task automatic idle_masters();
    for (int k = 0; k < 2; k++) begin
      mc[k] = 0; ms[k] = 0; mw[k] = 0; ma[k] = '0; md[k] = '0; msl[k] = '0;
    end
    s_ack_i = 0; s_err_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    idle_masters();
    wb_rst_n = 0;
    tick();
    tick();
    wb_rst_n = 1;
  endtask

  int len [2];
  int fire_at;

  initial begin
    @(negedge wb_clk);
    do_reset();

    // m0 alone reads 0x100, slave acks one cycle after STB
    mc[0] = 1; ms[0] = 1; ma[0] = 32'h100; msl[0] = 4'hF; s_dat_i = 32'hDEADBEEF;
    tick();
    #1 check_eq("rd_grant", grant_o, 2'b01);
    tick();
    s_ack_i = 1;
    #1 check_eq("rd_ack", {m0_ack_o, m1_ack_o, m0_dat_o}, {1'b1, 1'b0, 32'hDEADBEEF});
    tick();
    idle_masters();
    tick();

    // tie rounds from reset alternate 0,1,0,1
    do_reset();
    for (int r = 0; r < 4; r++) begin
      mc[0] = 1; mc[1] = 1;
      tick();
      #1 check_eq("rr_round", grant_o, (r % 2 == 0) ? 2'b01 : 2'b10);
      mc[0] = 0; mc[1] = 0;
      tick();
    end

    // release hands m1 the bus with no IDLE cycle
    do_reset();
    mc[0] = 1; mc[1] = 1;
    tick();
    mc[0] = 0;
    tick();
    #1 check_eq("handoff", grant_o, 2'b10);
    idle_masters();
    tick();

    // m1 back-to-back writes keep the grant while m0 waits
    do_reset();
    mc[1] = 1; ms[1] = 1; mw[1] = 1; msl[1] = 4'hF; ma[1] = 32'h10;
    tick();
    mc[0] = 1; ms[0] = 1;
    for (int i = 0; i < 3; i++) begin
      ma[1] = 32'h10 + 32'(4 * i); md[1] = $urandom; s_ack_i = 1;
      #1 check_eq("b2b_ack", {m1_ack_o, m0_ack_o, grant_o}, {1'b1, 1'b0, 2'b10});
      tick();
    end
    mc[1] = 0; ms[1] = 0; s_ack_i = 0;
    tick();
    #1 check_eq("b2b_release", grant_o, 2'b01);
    idle_masters();
    tick();

    // watchdog fires on the 8th stalled cycle
    do_reset();
    fires = 0; fire_at = -1;
    mc[0] = 1; ms[0] = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (fires == 1 && fire_at < 0) fire_at = i;
    end
    check_eq("wd_count", fires, 1);
    check_eq("wd_cycle", fire_at, 9);
    idle_masters();
    tick();
    mc[0] = 1; ms[0] = 1;
    for (int i = 1; i <= 8; i++) tick();
    s_ack_i = 1;
    #1 check_eq("wd_ack_wins", {m0_ack_o, m0_err_o, timeout_o}, 3'b100);
    tick();
    idle_masters();
    tick();

    // reset while m1 is mid-cycle
    do_reset();
    mc[1] = 1; ms[1] = 1;
    tick();
    wb_rst_n = 0; s_ack_i = 1;
    tick();
    #1 check_eq("rst_mid", {s_cyc_o, grant_o, m1_ack_o}, 4'b0000);
    wb_rst_n = 1; s_ack_i = 0; mc[0] = 1;
    tick();
    #1 check_eq("rst_rr", grant_o, 2'b01);
    idle_masters();
    tick();

    // 1000-cycle stall: disabled watchdog never fires and grant holds
    do_reset();
    nt_fires = 0;
    mc[0] = 1; ms[0] = 1;
    for (int i = 0; i < 1000; i++) tick();
    check_eq("nt_never_fires", nt_fires, 0);
    check_eq("nt_grant_held", nt_grant_o, 2'b01);
    idle_masters();
    tick();

    // randomized traffic
    do_reset();
    len[0] = 0; len[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (mc[k]) begin
          len[k]--;
          if (len[k] <= 0) mc[k] = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          mc[k] = 1; len[k] = $urandom_range(1, 20);
        end
        ms[k] = mc[k] && ($urandom_range(0, 3) != 0);
        mw[k] = $urandom; ma[k] = $urandom; md[k] = $urandom; msl[k] = $urandom;
      end
      s_ack_i  = ((i / 200) % 2 == 0) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 11) == 0);
      s_err_i  = ($urandom_range(0, 31) == 0);
      s_dat_i  = $urandom;
      wb_rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
